kyber_core_driver: RTL and testbench
====================================

# kyber_core_driver

Host-side command sequencer that drives the register-style command port of the Kyber key-generation core: the core's `i_data`/`i_addr`/`i_ctrl` inputs and its `o_data`/`o_valid` outputs. It takes commands from the host over a valid/ready interface and issues each one to the core as a single-cycle control strobe. It then collects the expected number of result words into a response FIFO that the host drains with its own valid/ready handshake. Timeouts, FIFO overflow and unsolicited core outputs are flagged as sticky errors.

## Interface
- BW_DATA, 32, data word width; matches the core.
- BW_ADDR, 4, core address width.
- BW_CTRL, 4, core control width; the value 0 is NOP.
- BW_NRSP, 8, width of the expected-response count.
- FIFO_DEPTH, 8, response FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT, 1023, maximum number of idle cycles allowed between responses.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  driver can accept a command.
- i_cmd_addr  in  BW_ADDR  core address.
- i_cmd_data  in  BW_DATA  core write data.
- i_cmd_ctrl  in  BW_CTRL  core opcode.
- i_cmd_nrsp  in  BW_NRSP  number of core `o_valid` words expected; 0 means none.
- o_core_data  out  BW_DATA  to core `i_data`.
- o_core_addr  out  BW_ADDR  to core `i_addr`.
- o_core_ctrl  out  BW_CTRL  to core `i_ctrl`.
- i_core_data  in  BW_DATA  from core `o_data`.
- i_core_valid  in  1  from core `o_valid`.
- o_rsp_valid  out  1  response FIFO not empty.
- o_rsp_data  out  BW_DATA  FIFO head word (first-word fall-through).
- i_rsp_ready  in  1  host pops the head word.
- o_busy  out  1  state is not IDLE.
- o_err_timeout  out  1  sticky timeout error.
- o_err_ovf  out  1  sticky FIFO overflow error.
- o_err_unexp  out  1  sticky unsolicited-response error.

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- `o_cmd_ready` is 1 exactly when the state is IDLE.
- A command is accepted when `i_cmd_valid` and `o_cmd_ready` are both high at a clock edge. On acceptance:
  - the command fields are registered into the core outputs,
  - the response counter is loaded with `i_cmd_nrsp`,
  - all three sticky errors are cleared,
  - the state moves to ISSUE.
- ISSUE lasts exactly one cycle.
  - `o_core_ctrl` carries the command opcode during this cycle only.
  - At the end of ISSUE, `o_core_ctrl` returns to 0. `o_core_addr` and `o_core_data` keep their values until the next command is accepted.
  - Next state is WAIT if the count is non-zero, otherwise IDLE.
- WAIT:
  - Each cycle with `i_core_valid` high pushes `i_core_data` into the FIFO and decrements the count.
  - When the count reaches 0, the state returns to IDLE.
  - The timeout counter clears on entry to WAIT and on every valid word, and increments otherwise.
  - When the timeout counter reaches TIMEOUT: `o_err_timeout` is set, the remaining count is abandoned, and the state returns to IDLE.
- A push while the FIFO is full and no pop occurs in the same cycle:
  - the word is dropped and `o_err_ovf` is set,
  - the response still counts against the expected total.
- If the FIFO is full and a pop happens in the same cycle, the push succeeds and no error is raised.
- `i_core_valid` seen in IDLE or ISSUE: the word is dropped and `o_err_unexp` is set.
- A command with opcode 0 is legal. It produces a NOP strobe and otherwise follows the normal flow.
- The FIFO is never flushed by a new command. Responses left over from earlier commands stay queued.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state goes to IDLE,
  - `o_core_ctrl`, `o_core_addr` and `o_core_data` go to 0,
  - the FIFO is emptied, so `o_rsp_valid` is 0,
  - all errors and `o_busy` go to 0.
  - A reset in the middle of an operation abandons it with no further strobe.
- `o_cmd_ready` is 1 from the first cycle after reset deasserts.
- Latency:
  - A command accepted at edge T drives the core opcode during cycle T+1.
  - With `nrsp` = 0, `o_cmd_ready` rises in cycle T+2, giving a back-to-back throughput of one command every 2 cycles.
- Response path: a core word captured at edge E appears on `o_rsp_valid`/`o_rsp_data` in cycle E+1.
- Pop rule: a pop happens on an edge where `o_rsp_valid` and `i_rsp_ready` are both high.
- Timeout point: the cycle count in WAIT is exact. The error is set on the edge after TIMEOUT consecutive cycles without a valid word.

## Structure
- Shared package `kyber_pkg` holds:
  - the `CTRL_NOP` (0) constant,
  - the FSM state encoding (IDLE=0, ISSUE=1, WAIT=2).
- Sub-module `kyber_resp_fifo` is a synchronous first-word-fall-through FIFO.
  - Parameters: BW_DATA and FIFO_DEPTH.
  - Ports: push, pop, full, empty, data.
  - Pointers carry one extra bit to tell full from empty; wrap-around is modulo FIFO_DEPTH.

## Test plan
- **Reset check:** reset, then a command addr=3, data=0xA5A5A5A5, ctrl=2, nrsp=0. Required: `o_core_ctrl` is 2 for exactly one cycle with addr=3 and data held; `o_cmd_ready` returns 2 cycles after acceptance.
- **Response capture:** a command with nrsp=3; the core model returns 0x11, 0x22, 0x33 with gaps. Required: the FIFO pops 0x11, 0x22, 0x33 in order, then the driver returns to IDLE with no errors.
- **Overflow:** nrsp=10 with FIFO_DEPTH=8, `i_rsp_ready`=0, 10 consecutive valid words. Required: 8 words are stored, `o_err_ovf`=1, and the state returns to IDLE. Repeat with simultaneous pop while full: no error.
- **Timeout:** nrsp=2 with only one response given. Required: `o_err_timeout` is set exactly TIMEOUT cycles after the last valid word and `o_cmd_ready` returns. The next command clears the error.
- **Unsolicited response:** `i_core_valid` pulsed in IDLE. Required: `o_err_unexp`=1 and the FIFO stays empty.
- **Mid-operation reset:** assert `i_rst` in WAIT with 2 words queued. Required: all outputs go to 0 immediately, the FIFO is empty, and `o_cmd_ready`=1 after release.

Source files
------------

// File: rtl/kyber_pkg.sv
// kyber_pkg
// Shared definitions for the Kyber core command driver: the NOP opcode and
// the sequencer state encoding.
// Ports: none (package).
package kyber_pkg;

    // Opcode value that leaves the core idle.
    localparam int CTRL_NOP = 0;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/kyber_core_driver_if.sv
// kyber_core_driver_if
// Bundles the host command channel, the core register port and the host
// response channel of the Kyber core driver.
// Modports:
//   slave  - the driver itself (takes commands, drives the core, offers responses)
//   master - the host/environment side (issues commands, models the core, pops)
interface kyber_core_driver_if #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 4,
    parameter int BW_CTRL = 4,
    parameter int BW_NRSP = 8
);

    // Host command channel
    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic [BW_ADDR-1:0] i_cmd_addr;
    logic [BW_DATA-1:0] i_cmd_data;
    logic [BW_CTRL-1:0] i_cmd_ctrl;
    logic [BW_NRSP-1:0] i_cmd_nrsp;

    // Core register port
    logic [BW_DATA-1:0] o_core_data;
    logic [BW_ADDR-1:0] o_core_addr;
    logic [BW_CTRL-1:0] o_core_ctrl;
    logic [BW_DATA-1:0] i_core_data;
    logic               i_core_valid;

    // Host response channel
    logic               o_rsp_valid;
    logic [BW_DATA-1:0] o_rsp_data;
    logic               i_rsp_ready;

    // Status
    logic               o_busy;
    logic               o_err_timeout;
    logic               o_err_ovf;
    logic               o_err_unexp;

    modport slave (
        input  i_cmd_valid, i_cmd_addr, i_cmd_data, i_cmd_ctrl, i_cmd_nrsp,
        input  i_core_data, i_core_valid, i_rsp_ready,
        output o_cmd_ready, o_core_data, o_core_addr, o_core_ctrl,
        output o_rsp_valid, o_rsp_data,
        output o_busy, o_err_timeout, o_err_ovf, o_err_unexp
    );

    modport master (
        output i_cmd_valid, i_cmd_addr, i_cmd_data, i_cmd_ctrl, i_cmd_nrsp,
        output i_core_data, i_core_valid, i_rsp_ready,
        input  o_cmd_ready, o_core_data, o_core_addr, o_core_ctrl,
        input  o_rsp_valid, o_rsp_data,
        input  o_busy, o_err_timeout, o_err_ovf, o_err_unexp
    );

endinterface

// File: rtl/kyber_resp_fifo.sv
// kyber_resp_fifo
// Synchronous first-word-fall-through FIFO holding core result words.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset (empties FIFO)
//   push, push_data   - write request and word
//   pop               - read request (ignored when empty)
//   full, empty       - occupancy flags
//   data              - head word, forced to 0 while empty
// A push while full only lands if a pop frees a slot in the same cycle.
module kyber_resp_fifo #(
    parameter int BW_DATA    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [BW_DATA-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [BW_DATA-1:0] data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [BW_DATA-1:0] mem_r [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Occupancy flags, effective push/pop and head-word output.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (empty) begin
            data = {BW_DATA{1'b0}};
        end else begin
            data = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/kyber_core_driver.sv
// kyber_core_driver
// Host-side sequencer for the Kyber key-generation core register port.
// Accepts one command at a time, strobes its opcode to the core for exactly one
// cycle, then collects the expected number of core result words into a
// response FIFO that the host drains. Timeout, overflow and unsolicited words
// are reported as sticky errors, cleared when the next command is accepted.
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset
//   bus          - command, core and response channels (slave modport)
module kyber_core_driver
    import kyber_pkg::*;
#(
    parameter int BW_DATA    = 32,
    parameter int BW_ADDR    = 4,
    parameter int BW_CTRL    = 4,
    parameter int BW_NRSP    = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic               i_clk,
    input  logic               i_rst,
    kyber_core_driver_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]   TMO_ONE  = TMO_W'(1);
    localparam logic [BW_NRSP-1:0] CNT_ONE  = BW_NRSP'(1);
    localparam logic [BW_CTRL-1:0] NOP      = BW_CTRL'(CTRL_NOP);

    state_t             state_r;
    logic [BW_DATA-1:0] core_data_r;
    logic [BW_ADDR-1:0] core_addr_r;
    logic [BW_CTRL-1:0] core_ctrl_r;
    logic [BW_NRSP-1:0] cnt_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               cmd_ready_r;
    logic               busy_r;
    logic               err_timeout_r;
    logic               err_ovf_r;
    logic               err_unexp_r;

    logic               pop_s;
    logic               push_s;
    logic               fifo_push_s;
    logic               ovf_s;
    logic               unexp_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [BW_DATA-1:0] fifo_data_s;

    // Response-path qualifiers: a word arriving while full is kept only if the
    // host pops in the same cycle; words outside WAIT are unsolicited.
    always_comb begin
        pop_s       = !fifo_empty_s && bus.i_rsp_ready;
        push_s      = (state_r == ST_WAIT) && bus.i_core_valid;
        fifo_push_s = push_s && (!fifo_full_s || pop_s);
        ovf_s       = push_s && fifo_full_s && !pop_s;
        unexp_s     = bus.i_core_valid && (state_r != ST_WAIT);
    end

    kyber_resp_fifo #(
        .BW_DATA    (BW_DATA),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (fifo_push_s),
        .push_data (bus.i_core_data),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .data      (fifo_data_s)
    );

    // Sequencer FSM with registered core strobes, status and sticky errors.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            core_data_r   <= {BW_DATA{1'b0}};
            core_addr_r   <= {BW_ADDR{1'b0}};
            core_ctrl_r   <= NOP;
            cnt_r         <= {BW_NRSP{1'b0}};
            tmo_r         <= {TMO_W{1'b0}};
            cmd_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b0;
            err_ovf_r     <= 1'b0;
            err_unexp_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_cmd_valid) begin
                        core_data_r   <= bus.i_cmd_data;
                        core_addr_r   <= bus.i_cmd_addr;
                        core_ctrl_r   <= bus.i_cmd_ctrl;
                        cnt_r         <= bus.i_cmd_nrsp;
                        err_timeout_r <= 1'b0;
                        err_ovf_r     <= 1'b0;
                        err_unexp_r   <= 1'b0;
                        cmd_ready_r   <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Opcode is a one-cycle strobe; addr/data stay put.
                    core_ctrl_r <= NOP;
                    tmo_r       <= {TMO_W{1'b0}};
                    if (cnt_r != {BW_NRSP{1'b0}}) begin
                        state_r <= ST_WAIT;
                    end else begin
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_core_valid) begin
                        // Dropped (overflowed) words still count as received.
                        tmo_r <= {TMO_W{1'b0}};
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            cmd_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        // TIMEOUT idle cycles elapsed: abandon remaining words.
                        err_timeout_r <= 1'b1;
                        cnt_r         <= {BW_NRSP{1'b0}};
                        cmd_ready_r   <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                default: begin
                    core_ctrl_r <= NOP;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
            // An unsolicited word on the acceptance edge still gets flagged.
            if (unexp_s) begin
                err_unexp_r <= 1'b1;
            end
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
        end
    end

    assign bus.o_cmd_ready   = cmd_ready_r;
    assign bus.o_core_data   = core_data_r;
    assign bus.o_core_addr   = core_addr_r;
    assign bus.o_core_ctrl   = core_ctrl_r;
    assign bus.o_rsp_valid   = !fifo_empty_s;
    assign bus.o_rsp_data    = fifo_data_s;
    assign bus.o_busy        = busy_r;
    assign bus.o_err_timeout = err_timeout_r;
    assign bus.o_err_ovf     = err_ovf_r;
    assign bus.o_err_unexp   = err_unexp_r;

endmodule

// File: tb/tb_kyber_core_driver.sv
// tb_kyber_core_driver
// Directed + randomized bench for kyber_core_driver. Expected responses are
// kept in a queue modelling the response FIFO contents; expected flags come
// from the command/response rules.
module tb_kyber_core_driver;

    localparam int BW_DATA    = 32;
    localparam int BW_ADDR    = 4;
    localparam int BW_CTRL    = 4;
    localparam int BW_NRSP    = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q [$];
    logic [31:0] cap_words [3];
    logic [31:0] w;
    logic [3:0]  addr_v;
    logic [3:0]  ctrl_v;
    logic [7:0]  nrsp_v;
    logic        exp_ovf;
    int          n;
    int          gap;

    kyber_core_driver_if #(
        .BW_DATA (BW_DATA), .BW_ADDR (BW_ADDR),
        .BW_CTRL (BW_CTRL), .BW_NRSP (BW_NRSP)
    ) bus ();

    kyber_core_driver #(
        .BW_DATA (BW_DATA), .BW_ADDR (BW_ADDR), .BW_CTRL (BW_CTRL),
        .BW_NRSP (BW_NRSP), .FIFO_DEPTH (FIFO_DEPTH), .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_errs(input string tag, input logic t, input logic o, input logic u);
        chk1({tag, "_err_timeout"}, bus.o_err_timeout, t);
        chk1({tag, "_err_ovf"}, bus.o_err_ovf, o);
        chk1({tag, "_err_unexp"}, bus.o_err_unexp, u);
    endtask

    // Present a command, wait (bounded) for acceptance, check the strobe cycle.
    task automatic send_cmd(input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] c, input logic [7:0] nr);
        int k;
        k = 0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = a;
        bus.i_cmd_data  = d;
        bus.i_cmd_ctrl  = c;
        bus.i_cmd_nrsp  = nr;
        while (bus.o_cmd_ready !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        chk1("cmd_ready_before_accept", bus.o_cmd_ready, 1'b1);
        tick();
        bus.i_cmd_valid = 1'b0;
        chk32("issue_ctrl", 32'(bus.o_core_ctrl), 32'(c));
        chk32("issue_addr", 32'(bus.o_core_addr), 32'(a));
        chk32("issue_data", bus.o_core_data, d);
        chk1("issue_busy", bus.o_busy, 1'b1);
        chk1("issue_ready", bus.o_cmd_ready, 1'b0);
        chk_errs("issue_cleared", 1'b0, 1'b0, 1'b0);
    endtask

    // One core result word for one cycle.
    task automatic drive_word(input logic [31:0] d);
        bus.i_core_valid = 1'b1;
        bus.i_core_data  = d;
        tick();
        bus.i_core_valid = 1'b0;
    endtask

    // Pop everything the model expects, in order, then confirm empty.
    task automatic drain();
        while (exp_q.size() > 0) begin
            chk1("drain_valid", bus.o_rsp_valid, 1'b1);
            chk32("drain_data", bus.o_rsp_data, exp_q.pop_front());
            bus.i_rsp_ready = 1'b1;
            tick();
            bus.i_rsp_ready = 1'b0;
        end
        chk1("drain_empty", bus.o_rsp_valid, 1'b0);
    endtask

    initial begin
        bus.i_cmd_valid  = 1'b0;
        bus.i_cmd_addr   = 4'd0;
        bus.i_cmd_data   = 32'd0;
        bus.i_cmd_ctrl   = 4'd0;
        bus.i_cmd_nrsp   = 8'd0;
        bus.i_core_valid = 1'b0;
        bus.i_core_data  = 32'd0;
        bus.i_rsp_ready  = 1'b0;
        cap_words[0] = 32'h11;
        cap_words[1] = 32'h22;
        cap_words[2] = 32'h33;
        tick();
        tick();

        // Reset state
        chk32("rst_ctrl", 32'(bus.o_core_ctrl), 32'd0);
        chk32("rst_addr", 32'(bus.o_core_addr), 32'd0);
        chk32("rst_data", bus.o_core_data, 32'd0);
        chk1("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        chk1("rst_busy", bus.o_busy, 1'b0);
        chk_errs("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk1("post_rst_ready", bus.o_cmd_ready, 1'b1);

        // Single strobe, nrsp=0: ready back two cycles after acceptance
        send_cmd(4'd3, 32'hA5A5A5A5, 4'd2, 8'd0);
        tick();
        chk32("strobe_end_ctrl", 32'(bus.o_core_ctrl), 32'd0);
        chk32("strobe_hold_addr", 32'(bus.o_core_addr), 32'd3);
        chk32("strobe_hold_data", bus.o_core_data, 32'hA5A5A5A5);
        chk1("strobe_ready_back", bus.o_cmd_ready, 1'b1);
        chk1("strobe_busy_low", bus.o_busy, 1'b0);

        // Response capture with random gaps
        send_cmd(4'd1, 32'h0, 4'd5, 8'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("cap_busy", bus.o_busy, 1'b1);
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            exp_q.push_back(cap_words[i]);
            drive_word(cap_words[i]);
        end
        chk1("cap_idle", bus.o_busy, 1'b0);
        chk1("cap_ready", bus.o_cmd_ready, 1'b1);
        chk_errs("cap", 1'b0, 1'b0, 1'b0);
        drain();

        // Randomized commands (first one is a NOP opcode)
        for (int k = 0; k < 6; k++) begin
            addr_v = 4'($urandom_range(0, 15));
            ctrl_v = (k == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            nrsp_v = 8'($urandom_range(1, 5));
            w = $urandom;
            send_cmd(addr_v, w, ctrl_v, nrsp_v);
            tick();
            chk32("rnd_ctrl_nop", 32'(bus.o_core_ctrl), 32'd0);
            for (int j = 0; j < int'(nrsp_v); j++) begin
                chk1("rnd_busy", bus.o_busy, 1'b1);
                gap = $urandom_range(0, 2);
                repeat (gap) tick();
                w = $urandom;
                exp_q.push_back(w);
                drive_word(w);
            end
            chk1("rnd_idle", bus.o_busy, 1'b0);
            chk_errs("rnd", 1'b0, 1'b0, 1'b0);
            drain();
        end

        // Overflow: 10 words into an 8-deep FIFO with no pops
        send_cmd(4'd2, 32'h0, 4'd7, 8'd10);
        tick();
        exp_ovf = 1'b0;
        for (int j = 0; j < 10; j++) begin
            w = $urandom;
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(w);
            else exp_ovf = 1'b1;
            drive_word(w);
        end
        chk1("ovf_flag", bus.o_err_ovf, exp_ovf);
        chk1("ovf_idle", bus.o_busy, 1'b0);
        chk1("ovf_ready", bus.o_cmd_ready, 1'b1);
        chk1("ovf_no_timeout", bus.o_err_timeout, 1'b0);
        drain();

        // Full FIFO with a pop in the same cycle as each extra push
        send_cmd(4'd2, 32'h0, 4'd7, 8'd10);
        tick();
        for (int j = 0; j < 10; j++) begin
            w = $urandom;
            if (j >= FIFO_DEPTH) begin
                bus.i_rsp_ready = 1'b1;
                chk32("full_pop_head", bus.o_rsp_data, exp_q.pop_front());
            end
            exp_q.push_back(w);
            drive_word(w);
            bus.i_rsp_ready = 1'b0;
        end
        chk1("full_pop_no_ovf", bus.o_err_ovf, 1'b0);
        chk1("full_pop_idle", bus.o_busy, 1'b0);
        drain();

        // Timeout: two expected, one delivered
        send_cmd(4'd1, 32'h0, 4'd3, 8'd2);
        tick();
        w = $urandom;
        exp_q.push_back(w);
        drive_word(w);
        n = 0;
        while (bus.o_err_timeout !== 1'b1 && n < TIMEOUT + 16) begin
            tick();
            n++;
        end
        chk32("timeout_cycles", 32'(n), 32'(TIMEOUT));
        chk1("timeout_flag", bus.o_err_timeout, 1'b1);
        chk1("timeout_ready", bus.o_cmd_ready, 1'b1);
        chk1("timeout_idle", bus.o_busy, 1'b0);
        drain();
        chk1("timeout_sticky", bus.o_err_timeout, 1'b1);
        send_cmd(4'd0, 32'h0, 4'd0, 8'd0);
        tick();

        // Unsolicited word in IDLE
        drive_word(32'hDEADBEEF);
        chk1("unexp_flag", bus.o_err_unexp, 1'b1);
        chk1("unexp_fifo_empty", bus.o_rsp_valid, 1'b0);
        chk1("unexp_idle", bus.o_busy, 1'b0);
        tick();
        chk1("unexp_sticky", bus.o_err_unexp, 1'b1);

        // Reset in WAIT with two words queued
        send_cmd(4'd5, 32'h12345678, 4'd9, 8'd4);
        tick();
        drive_word(32'hCAFE0001);
        drive_word(32'hCAFE0002);
        chk1("mid_rsp_valid", bus.o_rsp_valid, 1'b1);
        chk1("mid_busy", bus.o_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk32("mid_rst_ctrl", 32'(bus.o_core_ctrl), 32'd0);
        chk32("mid_rst_addr", 32'(bus.o_core_addr), 32'd0);
        chk32("mid_rst_data", bus.o_core_data, 32'd0);
        chk1("mid_rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        chk32("mid_rst_rsp_data", bus.o_rsp_data, 32'd0);
        chk1("mid_rst_busy", bus.o_busy, 1'b0);
        chk_errs("mid_rst", 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk1("mid_post_ready", bus.o_cmd_ready, 1'b1);
        chk1("mid_post_empty", bus.o_rsp_valid, 1'b0);
        chk32("mid_post_ctrl", 32'(bus.o_core_ctrl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
